// File: rtl/parallel2serial_mc_pkg.sv
// rtl/parallel2serial_mc_pkg.sv - shared state encoding and serial half-period derivation
package parallel2serial_mc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_SHIFT,
      ST_STALL,
      ST_LATCH,
      ST_DONE
   } state_e;

   // Half serial period in clk cycles, rounded up so s_clk never exceeds its target rate.
   function automatic int calc_half(input int p_clk_mhz, input int s_clk_mhz);
      int h;
      h = (p_clk_mhz + 2 * s_clk_mhz - 1) / (2 * s_clk_mhz);
      return (h < 1) ? 1 : h;
   endfunction

endpackage

// File: rtl/parallel2serial_mc_if.sv
// rtl/parallel2serial_mc_if.sv - parallel word handshake into the serializer
interface parallel2serial_mc_if #(
   parameter int DATA_BITS = 16,
   parameter int CHANNELS  = 1
);
   logic [CHANNELS*DATA_BITS-1:0] in_data;
   logic                          in_valid;
   logic                          in_last;
   logic                          in_ready;

   modport master (output in_data, output in_valid, output in_last, input in_ready);
   modport slave  (input in_data, input in_valid, input in_last, output in_ready);
endinterface

// File: rtl/parallel2serial_mc_serial_clk_gen.sv
// rtl/parallel2serial_mc_serial_clk_gen.sv - s_clk generator with rise/fall strobes
module serial_clk_gen #(
   parameter int HALF = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic en_i,
   input  logic clr_i,
   output logic s_clk_o,
   output logic rise_o,
   output logic fall_o
);
   localparam int CW = $clog2(2 * HALF);
   localparam logic [CW-1:0] RISE_AT = CW'(HALF - 1);
   localparam logic [CW-1:0] FALL_AT = CW'(2 * HALF - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          s_clk_q, s_clk_d;

   // Strobes mark the clk edge on which s_clk changes, so users act in lockstep with it.
   always_comb begin
      rise_o  = en_i && !clr_i && (cnt_q == RISE_AT);
      fall_o  = en_i && !clr_i && (cnt_q == FALL_AT);
      cnt_d   = cnt_q;
      s_clk_d = s_clk_q;
      if (clr_i) begin
         cnt_d   = '0;
         s_clk_d = 1'b0;
      end else if (en_i) begin
         cnt_d = fall_o ? '0 : cnt_q + 1'b1;
         if (rise_o)      s_clk_d = 1'b1;
         else if (fall_o) s_clk_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         s_clk_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         s_clk_q <= s_clk_d;
      end
   end

   assign s_clk_o = s_clk_q;
endmodule

// File: rtl/parallel2serial_mc.sv
// rtl/parallel2serial_mc.sv - multi-lane parallel-to-serial shifter with clear/latch framing
module parallel2serial_mc #(
   parameter int P_CLK_FREQ = 50,
   parameter int S_CLK_FREQ = 20,
   parameter int DATA_BITS  = 16,
   parameter int CHANNELS   = 1,
   parameter int MSB_FIRST  = 1,
   parameter int LATCH_EN   = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   parallel2serial_mc_if.slave   bus,
   output logic                  busy,
   output logic                  done,
   output logic                  s_clk,
   output logic                  s_clr,
   output logic                  s_lat,
   output logic [CHANNELS-1:0]   s_dat
);
   import parallel2serial_mc_pkg::*;

   localparam int HALF = calc_half(P_CLK_FREQ, S_CLK_FREQ);
   localparam int W    = CHANNELS * DATA_BITS;
   localparam int BW   = $clog2(DATA_BITS);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

   state_e         state_q, state_d;
   logic [W-1:0]   hold_q, hold_d, shreg_q, shreg_d, shreg_shift;
   logic           hold_last_q, hold_last_d, hold_full_q, hold_full_d, in_ready_q;
   logic           cur_last_q, cur_last_d, last_bit_q, last_bit_d;
   logic [BW-1:0]  bit_cnt_q, bit_cnt_d;
   logic           run, gen_clk, rise, fall, accept, load, word_end;

   // The generator also times CLEAR and LATCH; its clock is only exposed during SHIFT.
   assign run = (state_q == ST_CLEAR) || (state_q == ST_SHIFT) || (state_q == ST_LATCH);

   serial_clk_gen #(.HALF(HALF)) u_clk_gen (
      .clk     (clk),
      .rst     (rst),
      .en_i    (run),
      .clr_i   (!run),
      .s_clk_o (gen_clk),
      .rise_o  (rise),
      .fall_o  (fall)
   );

   assign accept   = bus.in_valid && in_ready_q;
   assign word_end = (state_q == ST_SHIFT) && fall && last_bit_q;
   assign load     = ((state_q == ST_CLEAR) && fall)
                   || (word_end && !cur_last_q && hold_full_q)
                   || ((state_q == ST_STALL) && hold_full_q);
   assign bus.in_ready = in_ready_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         hold_q      <= '0;
         hold_last_q <= 1'b0;
         hold_full_q <= 1'b0;
         in_ready_q  <= 1'b0;
         shreg_q     <= '0;
         cur_last_q  <= 1'b0;
         last_bit_q  <= 1'b0;
         bit_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         hold_last_q <= hold_last_d;
         hold_full_q <= hold_full_d;
         in_ready_q  <= !hold_full_d;
         shreg_q     <= shreg_d;
         cur_last_q  <= cur_last_d;
         last_bit_q  <= last_bit_d;
         bit_cnt_q   <= bit_cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (hold_full_q) state_d = ST_CLEAR;
         ST_CLEAR: if (fall) state_d = ST_SHIFT;
         ST_SHIFT: if (word_end) begin
            if (cur_last_q)        state_d = (LATCH_EN != 0) ? ST_LATCH : ST_DONE;
            else if (!hold_full_q) state_d = ST_STALL;
         end
         ST_STALL: if (hold_full_q) state_d = ST_SHIFT;
         ST_LATCH: if (fall) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      shreg_shift = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (MSB_FIRST != 0)
            shreg_shift[k*DATA_BITS +: DATA_BITS] = {shreg_q[k*DATA_BITS +: DATA_BITS-1], 1'b0};
         else
            shreg_shift[k*DATA_BITS +: DATA_BITS] = {1'b0, shreg_q[k*DATA_BITS+1 +: DATA_BITS-1]};
      end
   end

   // Word end is decoded on the rising edge so the falling edge acts on a settled flag.
   always_comb begin
      hold_d      = hold_q;
      hold_last_d = hold_last_q;
      hold_full_d = hold_full_q;
      shreg_d     = shreg_q;
      cur_last_d  = cur_last_q;
      bit_cnt_d   = bit_cnt_q;
      last_bit_d  = last_bit_q;
      if (load) begin
         shreg_d     = hold_q;
         cur_last_d  = hold_last_q;
         bit_cnt_d   = '0;
         hold_full_d = 1'b0;
      end else if ((state_q == ST_SHIFT) && fall && !word_end) begin
         shreg_d   = shreg_shift;
         bit_cnt_d = bit_cnt_q + 1'b1;
      end
      if (accept) begin
         hold_d      = bus.in_data;
         hold_last_d = bus.in_last;
         hold_full_d = 1'b1;
      end
      if (rise) last_bit_d = (bit_cnt_q == LAST_BIT);
   end

   always_comb begin
      busy  = (state_q != ST_IDLE);
      done  = (state_q == ST_DONE);
      s_clr = (state_q == ST_CLEAR);
      s_lat = (state_q == ST_LATCH);
      s_clk = gen_clk && (state_q == ST_SHIFT);
      s_dat = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         if ((state_q == ST_SHIFT) || (state_q == ST_STALL))
            s_dat[k] = (MSB_FIRST != 0) ? shreg_q[k*DATA_BITS + DATA_BITS - 1]
                                        : shreg_q[k*DATA_BITS];
      end
   end
endmodule
